// File: rtl/kth_largest_tracker.sv
// Streaming rank tracker: keeps the DEPTH largest samples in a sorted register array.
// Optional KTH_LARGEST_DEDUP_EN drops samples equal to a filled entry (distinct-value mode).
module kth_largest_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear,
  input  logic                         din_valid,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic [$clog2(DEPTH)-1:0]     rank_sel,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int RW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] top [DEPTH];
  logic [DATA_WIDTH-1:0] nxt [DEPTH];
  logic [DEPTH-1:0]      gt;
  logic                  drop;
  logic                  accept;

  // Each slot either keeps, takes din, or takes its upper neighbour; equal
  // values compare as not-greater, so a new duplicate lands below the old one.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      assign gt[g] = din > top[g];
      if (g == 0) begin : g_head
        assign nxt[g] = gt[g] ? din : top[g];
      end else begin : g_body
        assign nxt[g] = !gt[g] ? top[g] : (gt[g-1] ? top[g-1] : din);
      end
    end
  endgenerate

`ifdef KTH_LARGEST_DEDUP_EN
  always_comb begin
    drop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (din == top[i])) drop = 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign accept = din_valid && !drop;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      for (int i = 0; i < DEPTH; i++) top[i] <= '0;
      count <= '0;
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) top[i] <= nxt[i];
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end
  end

  // Out-of-range ranks (non-power-of-two DEPTH) fall through to zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rank_sel == RW'(i)) dout = top[i];
    end
  end

  assign dout_valid = CW'(rank_sel) < count;

endmodule
